// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a five-stage LEGv8-style core.
// It detects load-use hazards and inserts STALL_CYCLES bubbles (1..3). It holds
// the pipeline while data memory is busy, and it flushes the front end on a
// taken branch.
// Optional feature: define HAZARD_CTRL_PERF_EN to add saturating stall/flush
// performance counters (stall_cycles, flush_count).
module hazard_ctrl #(
   parameter int unsigned STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IF_ID_Instruction,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_Rd,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        ID_EX_Write,
   output logic        EX_MEM_Write,
   output logic        IF_Flush,
   output logic        ID_EX_Flush,
   output logic        EX_MEM_Flush,
   output logic        MEM_WB_Flush,
`ifdef HAZARD_CTRL_PERF_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
`endif
   output logic [1:0]  stall_state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] STALL_RELOAD = 2'(STALL_CYCLES - 1);

   state_t     state_q, state_d, eff_state;
   logic [1:0] cnt_q, cnt_d;

   logic [4:0] rn, rm;
   logic       rm_valid;
   logic       hazard;
   logic       unused_bits;

   assign unused_bits = ^IF_ID_Instruction[15:10];

   // Source register decode for the instruction held in IF/ID
   always_comb begin
      rn       = IF_ID_Instruction[9:5];
      rm       = '0;
      rm_valid = 1'b0;
      if (IF_ID_Instruction[28:25] == 4'b0101) begin
         rm       = IF_ID_Instruction[20:16];
         rm_valid = 1'b1;
      end else if ((IF_ID_Instruction[31:21] == 11'b11111000000) ||
                   (IF_ID_Instruction[31:24] == 8'b10110100)) begin
         rm       = IF_ID_Instruction[4:0];
         rm_valid = 1'b1;
      end
      hazard = ID_EX_MemRead && (ID_EX_Rd != 5'd31) &&
               ((ID_EX_Rd == rn) || (rm_valid && (ID_EX_Rd == rm)));
   end

   // Next-state, counter and enable/flush outputs in priority order
   always_comb begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      IF_Flush     = 1'b0;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Flush = 1'b0;
      MEM_WB_Flush = 1'b0;
      state_d      = state_q;
      cnt_d        = cnt_q;
      // leaving MEM_WAIT resumes the interrupted stall (or RUN) in the same cycle
      eff_state    = state_q;
      if (state_q == MEM_WAIT)
         eff_state = (cnt_q != 2'd0) ? LU_STALL : RUN;

      if (!rst_n) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         IF_Flush     = 1'b1;
         ID_EX_Flush  = 1'b1;
         EX_MEM_Flush = 1'b1;
         MEM_WB_Flush = 1'b1;
         state_d      = RUN;
         cnt_d        = '0;
      end else if (branch_taken) begin
         IF_Flush     = 1'b1;
         ID_EX_Flush  = 1'b1;
         EX_MEM_Flush = 1'b1;
         state_d      = RUN;
         cnt_d        = '0;
      end else if (mem_busy) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Flush = 1'b1;
         state_d      = MEM_WAIT;
      end else if (eff_state == LU_STALL) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Flush  = 1'b1;
         if (cnt_q <= 2'd1) begin
            state_d = RUN;
            cnt_d   = '0;
         end else begin
            state_d = LU_STALL;
            cnt_d   = cnt_q - 2'd1;
         end
      end else if (hazard) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Flush  = 1'b1;
         if (STALL_CYCLES > 1) begin
            state_d = LU_STALL;
            cnt_d   = STALL_RELOAD;
         end else begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end else begin
         state_d = RUN;
         cnt_d   = '0;
      end
   end

   // State and stall counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_state = state_q;

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, flush_count_q;

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (!PC_Write && (stall_cycles_q != '1))
            stall_cycles_q <= stall_cycles_q + 32'd1;
         if (branch_taken && (flush_count_q != '1))
            flush_count_q <= flush_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (STALL_CYCLES=1 and =3) share
// stimulus; each step checks {writes, flushes, stall_state} of both.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        mr, br, busy;
   logic [4:0]  rd;

   logic        pcw1, ifw1, idw1, exw1, iff1, idf1, exf1, mwf1;
   logic        pcw3, ifw3, idw3, exw3, iff3, idf3, exf3, mwf3;
   logic [1:0]  st1, st3;
`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] sc1, fc1, sc3, fc3;
`endif

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   localparam logic [7:0] NORM = 8'b1111_0000;
   localparam logic [7:0] STAL = 8'b0011_0100;
   localparam logic [7:0] BUSY = 8'b0000_0001;
   localparam logic [7:0] BRAN = 8'b1111_1110;
   localparam logic [7:0] RSTV = 8'b0000_1111;

   localparam logic [31:0] ADD_X2_X1_X3 = {11'b10001011000, 5'd3, 6'd0, 5'd1, 5'd2};
   localparam logic [31:0] ADDI_X5_X31  = {10'b1001000100, 12'd4, 5'd31, 5'd5};
   localparam logic [31:0] ADDI_X5_X7   = {10'b1001000100, 12'd4, 5'd7, 5'd5};
   localparam logic [31:0] STUR_X9_X4   = {11'b11111000000, 9'd0, 2'b00, 5'd4, 5'd9};
   localparam logic [31:0] CBZ_X6       = {8'b10110100, 19'd0, 5'd6};

   always #5 clk = ~clk;

   hazard_ctrl #(.STALL_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .IF_ID_Instruction(instr),
      .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .branch_taken(br), .mem_busy(busy),
      .PC_Write(pcw1), .IF_ID_Write(ifw1), .ID_EX_Write(idw1), .EX_MEM_Write(exw1),
      .IF_Flush(iff1), .ID_EX_Flush(idf1), .EX_MEM_Flush(exf1), .MEM_WB_Flush(mwf1),
`ifdef HAZARD_CTRL_PERF_EN
      .stall_cycles(sc1), .flush_count(fc1),
`endif
      .stall_state(st1)
   );

   hazard_ctrl #(.STALL_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .IF_ID_Instruction(instr),
      .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .branch_taken(br), .mem_busy(busy),
      .PC_Write(pcw3), .IF_ID_Write(ifw3), .ID_EX_Write(idw3), .EX_MEM_Write(exw3),
      .IF_Flush(iff3), .ID_EX_Flush(idf3), .EX_MEM_Flush(exf3), .MEM_WB_Flush(mwf3),
`ifdef HAZARD_CTRL_PERF_EN
      .stall_cycles(sc3), .flush_count(fc3),
`endif
      .stall_state(st3)
   );

   function automatic logic [9:0] ex(input logic [7:0] o, input logic [1:0] s);
      return {o, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_both(input string tag, input logic [9:0] e1, input logic [9:0] e3);
      chk({tag, "/s1"}, 32'({pcw1, ifw1, idw1, exw1, iff1, idf1, exf1, mwf1, st1}), 32'(e1));
      chk({tag, "/s3"}, 32'({pcw3, ifw3, idw3, exw3, iff3, idf3, exf3, mwf3, st3}), 32'(e3));
   endtask

   task automatic step(input string tag, input logic [31:0] ins, input logic m,
                       input logic [4:0] r, input logic b, input logic bz,
                       input logic [9:0] e1, input logic [9:0] e3);
      instr = ins; mr = m; rd = r; br = b; busy = bz;
      #1;
      check_both(tag, e1, e3);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; instr = ADD_X2_X1_X3; mr = 1'b0; rd = '0; br = 1'b0; busy = 1'b0;
      #3;
      check_both("rst_async", ex(RSTV, 2'd0), ex(RSTV, 2'd0));
      repeat (2) @(posedge clk);
      #1;
      check_both("rst_clocked", ex(RSTV, 2'd0), ex(RSTV, 2'd0));
      rst_n = 1'b1;

      step("normal",  ADD_X2_X1_X3, 1'b0, 5'd0, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));
      step("lu_rn",   ADD_X2_X1_X3, 1'b1, 5'd1, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("lu_b2",   ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("lu_b3",   ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("lu_done", ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      step("lu_rm",   ADD_X2_X1_X3, 1'b1, 5'd3, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("busy1",   ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b1, ex(BUSY,0), ex(BUSY,1));
      step("busy2",   ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b1, ex(BUSY,2), ex(BUSY,2));
      step("busy3",   ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b1, ex(BUSY,2), ex(BUSY,2));
      step("busy4",   ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b1, ex(BUSY,2), ex(BUSY,2));
      step("wake",    ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b0, ex(NORM,2), ex(STAL,2));
      step("wake_lu", ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("wake_end",ADD_X2_X1_X3, 1'b0, 5'd3, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      step("rd31",    ADDI_X5_X31,  1'b1, 5'd31, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));
      step("no_rm",   ADDI_X5_X7,   1'b1, 5'd0, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));
      step("addi_rn", ADDI_X5_X7,   1'b1, 5'd7, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("addi_b2", ADDI_X5_X7,   1'b0, 5'd7, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("addi_b3", ADDI_X5_X7,   1'b0, 5'd7, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("addi_end",ADDI_X5_X7,   1'b0, 5'd7, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      step("stur_rt", STUR_X9_X4,   1'b1, 5'd9, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("br_stall",STUR_X9_X4,   1'b0, 5'd9, 1'b1, 1'b0, ex(BRAN,0), ex(BRAN,1));
      step("br_after",STUR_X9_X4,   1'b0, 5'd9, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));
      step("br_haz",  ADD_X2_X1_X3, 1'b1, 5'd1, 1'b1, 1'b1, ex(BRAN,0), ex(BRAN,0));
      step("br_haz2", ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      step("rehaz1",  ADD_X2_X1_X3, 1'b1, 5'd1, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("rehaz2",  ADD_X2_X1_X3, 1'b1, 5'd1, 1'b0, 1'b0, ex(STAL,0), ex(STAL,1));
      step("rehaz3",  ADD_X2_X1_X3, 1'b1, 5'd1, 1'b0, 1'b0, ex(STAL,0), ex(STAL,1));
      step("rehaz4",  ADD_X2_X1_X3, 1'b1, 5'd1, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("rehaz5",  ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("rehaz6",  ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(STAL,1));
      step("rehaz7",  ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      step("cbz_rt",  CBZ_X6,       1'b1, 5'd6, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("cbz_busy",CBZ_X6,       1'b0, 5'd6, 1'b0, 1'b1, ex(BUSY,0), ex(BUSY,1));
      #1;
      check_both("memwait", ex(BUSY,2), ex(BUSY,2));
      rst_n = 1'b0;
      #1;
      check_both("rst_mid", ex(RSTV,0), ex(RSTV,0));
`ifdef HAZARD_CTRL_PERF_EN
      chk("perf_rst_sc1", sc1, 32'd0);
      chk("perf_rst_fc1", fc1, 32'd0);
      chk("perf_rst_sc3", sc3, 32'd0);
      chk("perf_rst_fc3", fc3, 32'd0);
`endif
      @(posedge clk);
      #1;
      check_both("rst_hold", ex(RSTV,0), ex(RSTV,0));
      busy = 1'b0;
      rst_n = 1'b1;
      step("post_rst1", CBZ_X6,     1'b0, 5'd6, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));
      step("post_rst2", CBZ_X6,     1'b0, 5'd6, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      step("perf_haz", ADD_X2_X1_X3, 1'b1, 5'd1, 1'b0, 1'b0, ex(STAL,0), ex(STAL,0));
      step("perf_br",  ADD_X2_X1_X3, 1'b0, 5'd1, 1'b1, 1'b0, ex(BRAN,0), ex(BRAN,1));
`ifdef HAZARD_CTRL_PERF_EN
      chk("perf_sc1", sc1, 32'd1);
      chk("perf_fc1", fc1, 32'd1);
      chk("perf_sc3", sc3, 32'd1);
      chk("perf_fc3", fc3, 32'd1);
`endif
      step("final",    ADD_X2_X1_X3, 1'b0, 5'd1, 1'b0, 1'b0, ex(NORM,0), ex(NORM,0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
